tdm_demux1_16: RTL and testbench
================================

# tdm_demux1_16

Time-division 1-to-16 demultiplexer: the receive-side counterpart of the 16:1 word mux. It accepts a serial stream of N-bit words framed by a start-of-frame marker, steers each word into one of 16 channel slots by an internal channel counter, and presents all 16 channels in parallel once a frame is complete. Outputs are double-buffered, so downstream logic sees a stable, coherent frame between `frame_valid` pulses.

## Interface
- `N`, default 3: word width of each channel.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `din`  input  N  incoming word.
- `din_valid`  input  1  `din` is valid this cycle.
- `sof`  input  1  qualified by `din_valid`; marks `din` as channel 0 (`o1`).
- `o1` … `o16`  output  N each  registered frame outputs; `o(k)` holds channel k-1.
- `frame_valid`  output  1  one-cycle pulse when `o1`..`o16` update.
- `sync_err`  output  1  one-cycle pulse on a framing error.
- `busy`  output  1  high while a frame is partially captured (state FILL).
- `ch_sel`  output  4  index of the next channel slot to be written.

## Operation
- Internal: 4-bit channel counter `chan`, 15-entry shadow store (channels 0–14), state ∈ {IDLE, FILL}.
- An "accept" is any cycle with `din_valid`=1. When `din_valid`=0, all state holds; there is no timeout.
- IDLE:
  - Accept with `sof`=1: shadow[0]←`din`, `chan`←1, go to FILL.
  - Accept with `sof`=0: word dropped, `sync_err` pulses, stay in IDLE.
- FILL, accept with `sof`=0 and `chan`<15: shadow[`chan`]←`din`, `chan`←`chan`+1.
- FILL, accept with `sof`=0 and `chan`=15 (completion):
  - `o1`..`o15` ← shadow[0..14].
  - `o16` ← `din`.
  - `frame_valid` pulses, `chan`←0, go to IDLE.
- FILL, accept with `sof`=1 (early sof, any `chan` including 15):
  - `sync_err` pulses and the partial frame is discarded.
  - The `sof` word starts a new frame: shadow[0]←`din`, `chan`←1, stay in FILL.
  - `o*` are unchanged and `frame_valid` stays low.
- `o*` change only on completion. A partial or aborted frame is never visible on the outputs.
- Back-to-back frames: a `sof` accept on the cycle immediately after completion is taken normally, with no bubble.
- `busy` = (state == FILL). `ch_sel` = `chan`.

## Timing
- Reset values (asynchronous, immediate):
  - `o1`..`o16` = 0, `frame_valid` = 0, `sync_err` = 0, `busy` = 0, `ch_sel` = 0.
  - state = IDLE; shadow contents don't-care, never exposed.
- All outputs are registered.
- The completion accept at edge E updates `o*` and raises `frame_valid` right after edge E; `frame_valid` drops after E+1 unless another completion occurs.
- `sync_err` is high for the single cycle after the offending edge.
- Minimum frame period is 16 cycles: with `din_valid` held high, `frame_valid` pulses every 16 cycles.
- `rst` asserted mid-frame aborts the frame: `o*` clear to 0, no `frame_valid`. The first accept after release must carry `sof`.

## Structure
- Package `tdm_demux_pkg`:
  - `NUM_CH`=16, `CH_W`=4.
  - state enum {IDLE, FILL}.
- Sub-module `dec4_16`: combinational 4-to-16 one-hot decoder producing shadow write enables from `chan`, gated by the accept.
- Top module holds the FSM, the counter, the shadow store and the output bank.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately. Release, then drive 16 words 1..16 (wrapping mod 2^N) with `sof` on the first → after the 16th edge, `o1`=1 … `o16`=16 mod 2^N, one `frame_valid` pulse, `busy` drops.
- Gapped input: same frame with `din_valid` low on alternating cycles → identical outputs; `frame_valid` only after the 16th accept; `ch_sel` holds during gaps.
- Early sof: 7 words of frame A (all 5), then `sof` with value 2 plus 15 words of value 3 → `sync_err` one pulse at the restart; `o1`=2, `o2`..`o16`=3; no `frame_valid` for frame A.
- No-sof in IDLE: 3 accepts with `sof`=0 after reset → 3 `sync_err` pulses, `busy`=0, `ch_sel`=0, `o*` stay 0.
- Back-to-back: two continuous frames (values 1s then 6s) → `frame_valid` pulses 16 cycles apart; `o*` all 1 for exactly 16 cycles, then all 6.
- Reset mid-frame: `rst` after 10 words of a frame following a completed frame → `o*`=0, no `frame_valid`; a fresh full frame then completes normally.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared constants and FSM state type for the 1-to-16 TDM demultiplexer.
package tdm_demux_pkg;
    localparam int NUM_CH = 16;
    localparam int CH_W = 4;
    typedef enum logic {IDLE, FILL} state_t;
endpackage

// File: rtl/dec4_16.sv
// dec4_16: combinational 4-to-16 one-hot decoder with enable, used as shadow-store write strobes.
module dec4_16
    import tdm_demux_pkg::*;
(
    input  logic [CH_W-1:0]   sel,
    input  logic              en,
    output logic [NUM_CH-1:0] oh
);
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) oh[k] = en && (sel == CH_W'(k));
    end
endmodule

// File: rtl/tdm_demux1_16.sv
// tdm_demux1_16: framed serial-to-parallel 1:16 word demux with double-buffered outputs.
module tdm_demux1_16
    import tdm_demux_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    input  logic         sof,
    output logic [N-1:0] o1,
    output logic [N-1:0] o2,
    output logic [N-1:0] o3,
    output logic [N-1:0] o4,
    output logic [N-1:0] o5,
    output logic [N-1:0] o6,
    output logic [N-1:0] o7,
    output logic [N-1:0] o8,
    output logic [N-1:0] o9,
    output logic [N-1:0] o10,
    output logic [N-1:0] o11,
    output logic [N-1:0] o12,
    output logic [N-1:0] o13,
    output logic [N-1:0] o14,
    output logic [N-1:0] o15,
    output logic [N-1:0] o16,
    output logic         frame_valid,
    output logic         sync_err,
    output logic         busy,
    output logic [3:0]   ch_sel
);
    state_t            state_q, state_d;
    logic [CH_W-1:0]   chan_q, chan_d, wr_sel;
    logic              fv_q, fv_d, se_q, se_d;
    logic [N-1:0]      sh_q [NUM_CH-1];
    logic [N-1:0]      sh_d [NUM_CH-1];
    logic [N-1:0]      o_q [NUM_CH];
    logic [N-1:0]      o_d [NUM_CH];
    logic [NUM_CH-1:0] we;

    // A sof word always lands in slot 0; strobe 15 doubles as the completion strobe.
    assign wr_sel = sof ? '0 : chan_q;

    dec4_16 u_dec (
        .sel(wr_sel),
        .en (din_valid && (sof || state_q == FILL)),
        .oh (we)
    );

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        fv_d    = 1'b0;
        se_d    = 1'b0;
        sh_d    = sh_q;
        o_d     = o_q;
        for (int k = 0; k < NUM_CH - 1; k++) if (we[k]) sh_d[k] = din;
        if (we[NUM_CH-1]) begin
            for (int k = 0; k < NUM_CH - 1; k++) o_d[k] = sh_q[k];
            o_d[NUM_CH-1] = din;
        end
        if (din_valid) begin
            if (sof) begin
                se_d    = (state_q == FILL);
                state_d = FILL;
                chan_d  = CH_W'(1);
            end else if (state_q == IDLE) begin
                se_d = 1'b1;
            end else if (chan_q == CH_W'(NUM_CH - 1)) begin
                fv_d    = 1'b1;
                chan_d  = '0;
                state_d = IDLE;
            end else begin
                chan_d = chan_q + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            chan_q  <= '0;
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) o_q[k] <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            fv_q    <= fv_d;
            se_q    <= se_d;
            o_q     <= o_d;
        end
    end

    // Shadow contents are never exposed before being rewritten, so no reset.
    always_ff @(posedge clk) sh_q <= sh_d;

    assign o1  = o_q[0];
    assign o2  = o_q[1];
    assign o3  = o_q[2];
    assign o4  = o_q[3];
    assign o5  = o_q[4];
    assign o6  = o_q[5];
    assign o7  = o_q[6];
    assign o8  = o_q[7];
    assign o9  = o_q[8];
    assign o10 = o_q[9];
    assign o11 = o_q[10];
    assign o12 = o_q[11];
    assign o13 = o_q[12];
    assign o14 = o_q[13];
    assign o15 = o_q[14];
    assign o16 = o_q[15];
    assign frame_valid = fv_q;
    assign sync_err    = se_q;
    assign busy        = (state_q == FILL);
    assign ch_sel      = chan_q;
endmodule

// File: tb/tb_tdm_demux1_16.sv
// tb_tdm_demux1_16: directed stimulus with a frame scoreboard checked by an independent monitor.
module tb_tdm_demux1_16;
    localparam int N = 3;
    localparam int FW = 16 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din_valid = 1'b0;
    logic sof = 1'b0;
    logic [N-1:0] din = '0;
    logic [N-1:0] o1, o2, o3, o4, o5, o6, o7, o8, o9, o10, o11, o12, o13, o14, o15, o16;
    logic frame_valid, sync_err, busy;
    logic [3:0] ch_sel;

    tdm_demux1_16 #(.N(N)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7), .o8(o8),
        .o9(o9), .o10(o10), .o11(o11), .o12(o12), .o13(o13), .o14(o14), .o15(o15), .o16(o16),
        .frame_valid(frame_valid), .sync_err(sync_err), .busy(busy), .ch_sel(ch_sel)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int se_cnt = 0;
    int fv_cnt = 0;
    int fv_last = -100;
    int fv_prev = -100;
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] held = '0;
    wire  [FW-1:0] obs = {o16, o15, o14, o13, o12, o11, o10, o9, o8, o7, o6, o5, o4, o3, o2, o1};

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: pops the expected frame on every frame_valid, otherwise outputs must hold.
    always @(negedge clk) begin
        if (rst) begin
            held = '0;
            chk("reset_outs", 64'(obs), 64'(0));
        end else begin
            if (sync_err) se_cnt++;
            if (frame_valid) begin
                fv_prev = fv_last;
                fv_last = cyc;
                fv_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got %0h want none", obs);
                end else begin
                    held = exp_q.pop_front();
                    chk("frame", 64'(obs), 64'(held));
                end
            end else begin
                chk("hold", 64'(obs), 64'(held));
            end
        end
    end

    function automatic logic [FW-1:0] mk(input logic [N-1:0] v0, input logic [N-1:0] vr);
        logic [FW-1:0] f;
        for (int k = 0; k < 16; k++) f[k*N +: N] = (k == 0) ? v0 : vr;
        return f;
    endfunction

    // Hand-written ramp 1..16 mod 8, channel 0 at the LSB.
    localparam logic [FW-1:0] RAMP = {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1,
                                      3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};

    task automatic send(input logic [N-1:0] d, input logic s);
        @(negedge clk);
        din = d;
        sof = s;
        din_valid = 1'b1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            din_valid = 1'b0;
            sof = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [FW-1:0] f, input bit gapped);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) exp_q.push_back(f);
            send(f[k*N +: N], k == 0);
            if (gapped && k < 15) begin
                gap(1);
                if (k == 4) begin
                    chk("gap_ch_sel", 64'(ch_sel), 64'(5));
                    chk("gap_busy", 64'(busy), 64'(1));
                    gap(1);
                    chk("gap_ch_sel_hold", 64'(ch_sel), 64'(5));
                end
            end
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        din_valid = 1'b0;
        sof = 1'b0;
        #1;
        chk("async_rst_outs", 64'(obs), 64'(0));
        chk("async_rst_flags", 64'({frame_valid, sync_err, busy, ch_sel}), 64'(0));
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int se0, fv0;
        gap(2);
        #1 rst = 1'b0;
        chk("init_flags", 64'({frame_valid, sync_err, busy, ch_sel}), 64'(0));

        // plain ramp frame
        fv0 = fv_cnt;
        send_frame(RAMP, 1'b0);
        gap(2);
        chk("ramp_fv_count", 64'(fv_cnt - fv0), 64'(1));
        chk("ramp_busy", 64'(busy), 64'(0));
        chk("ramp_ch_sel", 64'(ch_sel), 64'(0));

        // asynchronous reset with non-zero outputs
        async_reset();

        // words without sof while idle are dropped
        se0 = se_cnt;
        repeat (3) send(3'd7, 1'b0);
        gap(2);
        chk("nosof_sync_err", 64'(se_cnt - se0), 64'(3));
        chk("nosof_busy", 64'(busy), 64'(0));
        chk("nosof_ch_sel", 64'(ch_sel), 64'(0));
        chk("nosof_se_low", 64'(sync_err), 64'(0));

        // gapped ramp frame
        fv0 = fv_cnt;
        send_frame(RAMP, 1'b1);
        gap(2);
        chk("gapped_fv_count", 64'(fv_cnt - fv0), 64'(1));
        chk("gapped_busy", 64'(busy), 64'(0));

        // early sof aborts partial frame A
        se0 = se_cnt;
        fv0 = fv_cnt;
        send(3'd5, 1'b1);
        repeat (6) send(3'd5, 1'b0);
        send_frame(mk(3'd2, 3'd3), 1'b0);
        gap(2);
        chk("early_sof_sync_err", 64'(se_cnt - se0), 64'(1));
        chk("early_sof_fv_count", 64'(fv_cnt - fv0), 64'(1));

        // back-to-back frames
        se0 = se_cnt;
        send_frame(mk(3'd1, 3'd1), 1'b0);
        send_frame(mk(3'd6, 3'd6), 1'b0);
        gap(2);
        chk("b2b_spacing", 64'(fv_last - fv_prev), 64'(16));
        chk("b2b_no_sync_err", 64'(se_cnt - se0), 64'(0));

        // reset in the middle of a frame
        fv0 = fv_cnt;
        send(3'd4, 1'b1);
        repeat (9) send(3'd4, 1'b0);
        async_reset();
        gap(3);
        chk("midrst_no_fv", 64'(fv_cnt - fv0), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        send_frame(RAMP, 1'b0);
        gap(2);
        chk("midrst_fresh_fv", 64'(fv_cnt - fv0), 64'(1));
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
